seq_det_ctrl: RTL

//  Run controller for a programmable serial pattern detector. Latches a pattern, a match target
//  and a no-match timeout, then arms on start. Counts overlapping matches on a valid-qualified
//  bit stream and ends the run on target reached, timeout or abort.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_det_match.sv | 54 +++++
 rtl/seq_det_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector run controller.
// State encoding and the reset-time default pattern.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READY = 2'b01,
    RUN   = 2'b10
  } state_e;

  // Alternating ...0101; the low PAT_W bits form the reset pattern.
  localparam logic [31:0] DEF_PAT = 32'h5555_5555;

endpackage

// File: rtl/seq_det_match.sv
// Pattern matcher: history shift register, fill counter, compare.
// hit_out is the same-cycle match; match_out is its registered copy.
module seq_det_match #(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_in,
  input  logic             shift_in,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern_in,
  output logic             hit_out,
  output logic             match_out
);
  import seq_det_pkg::*;

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clr_in) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_in) begin
      hist_d  = {hist_q[PAT_W-2:0], bit_in};
      fill_d  = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
      // History is kept on a hit so overlapping matches are found.
      match_d = (hist_d == pattern_in) && (fill_d == FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign hit_out   = match_d;
  assign match_out = match_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for a programmable serial pattern detector.
// Optional sticky interrupt flag: define SEQ_DET_CTRL_IRQ_EN.
module seq_det_ctrl #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clock_in,
  input  logic             rst_n_in,
  input  logic             cfg_valid_in,
  output logic             cfg_ready_out,
  input  logic [PAT_W-1:0] cfg_pattern_in,
  input  logic [CNT_W-1:0] cfg_target_in,
  input  logic [TO_W-1:0]  cfg_timeout_in,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic             data_valid_in,
  input  logic             data_in,
  output logic             busy_out,
  output logic             match_out,
  output logic             done_out,
  output logic             timeout_out,
`ifdef SEQ_DET_CTRL_IRQ_EN
  output logic             irq_out,
  input  logic             irq_clr_in,
`endif
  output logic [CNT_W-1:0] match_count_out
);
  import seq_det_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  tmr_q, tmr_d;
  logic             done_q, done_d;
  logic             tout_q, tout_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             clr, shift, hit;
  logic [CNT_W:0]   cnt_inc;

  assign shift   = (state_q == RUN) && data_valid_in;
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  seq_det_match #(.PAT_W(PAT_W)) u_match (
    .clk        (clock_in),
    .rst_n      (rst_n_in),
    .clr_in     (clr),
    .shift_in   (shift),
    .bit_in     (data_in),
    .pattern_in (pat_q),
    .hit_out    (hit),
    .match_out  (match_out)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    tgt_d   = tgt_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    tout_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_in) begin
          pat_d   = cfg_pattern_in;
          tgt_d   = cfg_target_in;
          to_d    = cfg_timeout_in;
          state_d = READY;
        end
      end
      READY: begin
        if (cfg_valid_in) begin
          pat_d = cfg_pattern_in;
          tgt_d = cfg_target_in;
          to_d  = cfg_timeout_in;
        end
        if (start_in) begin
          cnt_d   = '0;
          tmr_d   = '0;
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hit && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        tmr_d = hit ? '0 : tmr_q + TO_W'(1);
        // abort > done > timeout; a pending match still counts.
        if (abort_in) begin
          state_d = READY;
        end else if (hit && tgt_q != '0 &&
                     cnt_inc == {1'b0, tgt_q}) begin
          done_d  = 1'b1;
          state_d = READY;
        end else if (!hit && to_q != '0 &&
                     tmr_q == to_q - TO_W'(1)) begin
          tout_d  = 1'b1;
          state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d != RUN);
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      pat_q   <= DEF_PAT[PAT_W-1:0];
      tgt_q   <= '0;
      to_q    <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      tgt_q   <= tgt_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign cfg_ready_out   = rdy_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign timeout_out     = tout_q;
  assign match_count_out = cnt_q;

`ifdef SEQ_DET_CTRL_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (irq_clr_in) irq_d = 1'b0;
    if (done_d || tout_d) irq_d = 1'b1;
  end

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) irq_q <= 1'b0;
    else           irq_q <= irq_d;
  end

  assign irq_out = irq_q;
`endif

endmodule
